font_access_arbiter: RTL

// Shares the single-port font RAM (CHARS glyphs x ROWS_PER_CHAR rows x CHAR_WIDTH bits)

---
 rtl/font_access_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/font_access_arbiter.sv
// -----------------------------------------------------------------------------
// font_access_arbiter
//   Shares one single-port font RAM between the video row fetcher and a host
//   upload/readback port. (char,row) pairs become linear addresses
//   char*ROWS_PER_CHAR + row. Video owns the RAM slot after any video request
//   and always completes in exactly 2 cycles. Host requests run in idle slots
//   through a small FSM and finish with a one-cycle ack.
//
// Ports
//   clk_i, reset_i            clock, synchronous active-high reset
//   video_req_i               fetch request, always accepted
//   video_char_i/row_i        glyph index / row within glyph
//   video_valid_o             bitmap valid, 2 cycles after video_req_i
//   video_bitmap_o            fetched row, 0 when the request was out of range
//   host_req_i                held with operands until host_ack_o
//   host_we_i                 1 = write host_wdata_i, 0 = read
//   host_char_i/row_i         glyph index / row within glyph
//   host_wdata_i              write data
//   host_ack_o                one-cycle completion pulse
//   host_err_o                with ack: out-of-range request, RAM untouched
//   host_rdata_o              read data with ack (0 on error or write)
//   host_starved_o            host has waited more than STARVE_LIMIT cycles
//   ram_address_o/wdata_o/we_o  registered RAM port A controls
//   ram_rdata_i               RAM data, valid 1 cycle after ram_address_o
// -----------------------------------------------------------------------------
module font_access_arbiter #(
    parameter int  CHAR_WIDTH    = 16,
    parameter int  ROWS_PER_CHAR = 20,
    parameter int  CHARS         = 1024,
    parameter int  RAM_WIDTH     = 15,
    parameter int  ROW_WIDTH     = 5,
    parameter int  STARVE_LIMIT  = 64,
    localparam int CHAR_IDX_W    = $clog2(CHARS)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  video_req_i,
    input  logic [CHAR_IDX_W-1:0] video_char_i,
    input  logic [ROW_WIDTH-1:0]  video_row_i,
    output logic                  video_valid_o,
    output logic [CHAR_WIDTH-1:0] video_bitmap_o,
    input  logic                  host_req_i,
    input  logic                  host_we_i,
    input  logic [CHAR_IDX_W-1:0] host_char_i,
    input  logic [ROW_WIDTH-1:0]  host_row_i,
    input  logic [CHAR_WIDTH-1:0] host_wdata_i,
    output logic                  host_ack_o,
    output logic                  host_err_o,
    output logic [CHAR_WIDTH-1:0] host_rdata_o,
    output logic                  host_starved_o,
    output logic [RAM_WIDTH-1:0]  ram_address_o,
    output logic [CHAR_WIDTH-1:0] ram_wdata_o,
    output logic                  ram_we_o,
    input  logic [CHAR_WIDTH-1:0] ram_rdata_i
);

    localparam int AW1   = RAM_WIDTH + 1;
    localparam int CW1   = CHAR_IDX_W + 1;
    localparam int RW1   = ROW_WIDTH + 1;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 2);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE, S_ERR} host_state_e;

    // Linear address kept one bit wider than the RAM so an overflow can be
    // detected instead of silently wrapping onto another glyph.
    function automatic logic [AW1-1:0] lin_addr(input logic [CHAR_IDX_W-1:0] c,
                                                input logic [ROW_WIDTH-1:0]  r);
        return AW1'(c) * AW1'(ROWS_PER_CHAR) + AW1'(r);
    endfunction

    function automatic logic idx_ok(input logic [CHAR_IDX_W-1:0] c,
                                    input logic [ROW_WIDTH-1:0]  r);
        return ({1'b0, c} < CW1'(CHARS)) && ({1'b0, r} < RW1'(ROWS_PER_CHAR));
    endfunction

    logic [AW1-1:0]        vid_full, host_full;
    logic                  vid_ok, host_ok;

    host_state_e           state_q, state_d;
    logic                  host_accept;
    logic                  ack_q, ack_d, err_q, err_d, rd_q, rd_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  starved_q, starved_d;
    logic [RAM_WIDTH-1:0]  ram_addr_q, ram_addr_d;
    logic [CHAR_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
    logic                  ram_we_q, ram_we_d;
    logic [1:0]            vid_vld_q, vid_ok_q;   // stage 0 = address cycle, 1 = data cycle

    assign vid_full  = lin_addr(video_char_i, video_row_i);
    assign host_full = lin_addr(host_char_i, host_row_i);
    assign vid_ok    = idx_ok(video_char_i, video_row_i) && !vid_full[RAM_WIDTH];
    assign host_ok   = idx_ok(host_char_i, host_row_i) && !host_full[RAM_WIDTH];

    always_comb begin
        state_d     = state_q;
        host_accept = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A video request claims the next RAM slot, so the host waits.
                if (host_req_i && !video_req_i) begin
                    host_accept = 1'b1;
                    state_d     = host_ok ? S_ISSUE : S_ERR;
                end
            end
            S_ISSUE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        ack_d = (state_d == S_DONE) || (state_d == S_ERR);
        err_d = (state_d == S_ERR);
        rd_d  = host_accept ? !host_we_i : rd_q;

        cnt_d = cnt_q;
        if (host_accept)
            cnt_d = '0;
        else if (state_q == S_IDLE && host_req_i && cnt_q != '1)
            cnt_d = cnt_q + 1'b1;
        starved_d = (cnt_d > CNT_W'(STARVE_LIMIT));

        // Address/data hold between accesses; only the write strobe drops.
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_we_d    = 1'b0;
        if (video_req_i) begin
            ram_addr_d = vid_ok ? vid_full[RAM_WIDTH-1:0] : '0;
        end else if (host_accept && host_ok) begin
            ram_addr_d  = host_full[RAM_WIDTH-1:0];
            ram_we_d    = host_we_i;
            ram_wdata_d = host_wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            rd_q        <= 1'b0;
            cnt_q       <= '0;
            starved_q   <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
            vid_vld_q   <= '0;
            vid_ok_q    <= '0;
        end else begin
            state_q     <= state_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            rd_q        <= rd_d;
            cnt_q       <= cnt_d;
            starved_q   <= starved_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_we_q    <= ram_we_d;
            vid_vld_q   <= {vid_vld_q[0], video_req_i};
            vid_ok_q    <= {vid_ok_q[0], vid_ok};
        end
    end

    // The RAM output is itself a register, so read data is steered straight
    // from it; this is what keeps video and host read latency at 2 cycles.
    assign video_valid_o  = vid_vld_q[1];
    assign video_bitmap_o = (vid_vld_q[1] && vid_ok_q[1]) ? ram_rdata_i : '0;
    assign host_ack_o     = ack_q;
    assign host_err_o     = err_q;
    assign host_rdata_o   = (ack_q && rd_q && !err_q) ? ram_rdata_i : '0;
    assign host_starved_o = starved_q;
    assign ram_address_o  = ram_addr_q;
    assign ram_wdata_o    = ram_wdata_q;
    assign ram_we_o       = ram_we_q;

endmodule
